seq_gen: RTL and testbench
==========================

# seq_gen

Parametrised, mode-selectable sequence generator for lab sequential datapaths. It is the generalised successor to the fixed 3-bit T-flip-flop sequence circuit: width, modulus and counting mode are configurable, and it adds enable, parallel load and a terminal-count flag. State bits are built from a T-flip-flop cell. The block drives display, sequencing and timing logic elsewhere in the lab designs.

## Interface
- WIDTH, 3: state/output width; legal range 2..16.
- MAX_COUNT, 2**WIDTH-1: highest count in the binary and Gray modes; legal range 1..2**WIDTH-1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advances the sequence by one step per clock while high.
- mode  in  2  sequence select: 00 binary up, 01 binary down, 10 Gray up, 11 Johnson.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- Q  out  WIDTH  registered sequence output.
- tc  out  1  terminal-count flag; combinational, equals en AND (current state is the last state of the mode).

## Operation
- Internal state register is `st[WIDTH-1:0]`.
- Priority at each clock edge: reset > load > en > hold.
- reset: st=0 and Q=0. tc is 0 while en=0.
- load: st = min(load_val, MAX_COUNT) in modes 00/01/10. In mode 11, st = load_val raw. load acts regardless of en.
- Binary up (00): st+1. At MAX_COUNT, wraps to 0. Q=st. Terminal state is MAX_COUNT.
- Binary down (01): st-1. At 0, wraps to MAX_COUNT. Q=st. Terminal state is 0.
- Gray up (10): st counts as in mode 00. Q = next_st ^ (next_st>>1), registered on the same edge, so Q never lags st. Terminal state is st==MAX_COUNT.
- Johnson (11): st = {st[WIDTH-2:0], ~st[WIDTH-1]}, giving a 2*WIDTH-state cycle. Q=st. Terminal state is {1'b1, {WIDTH-1{1'b0}}}.
- Legal Johnson codes are of the form 1..10..0 or 0..01..1. Any other pattern is illegal: on the next enabled step st=0, so the block self-corrects in one cycle.
- If st > MAX_COUNT when entering modes 00/01/10 (possible after Johnson use), the next enabled step sets st=0.
- A mode change takes effect on the next enabled edge. st is not cleared on a mode change.
- All arithmetic is modulo 2**WIDTH before the MAX_COUNT wrap check. There are no carries outside WIDTH bits.

## Timing
- Q and st update only on rising clk. Latency from en/load/reset to Q is 1 cycle.
- tc is valid in the same cycle as the state it flags; it has 0 latency from en.
- reset asserted mid-sequence: Q=0 on the following edge, regardless of load or en.
- load and en high together: load wins, and no step occurs that cycle.
- en held high: exactly one step per cycle, with no bubbles at a wrap.

## Configuration
- SEQ_GEN_GRAY_EN defined: mode 10 behaves as specified above.
- SEQ_GEN_GRAY_EN undefined: the Gray encoder is not built, and mode 10 behaves identically to mode 00 (binary up, Q=st, same tc).

## Structure
- Shared package seq_gen_pkg holds:
  - the mode enum: MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_GRAY=2'b10, MODE_JOHNSON=2'b11;
  - a function bin2gray;
  - a function johnson_legal.
- One sub-module, seq_tff: a single-bit T flip-flop with synchronous active-high reset, instantiated WIDTH times for st.
- Each bit's T input is st[i] ^ next_st[i]. Next-state and terminal decode are a combinational block in seq_gen.

## Test plan
- WIDTH=3, MAX_COUNT=5, mode 00, en=1 for 8 cycles after reset -> Q = 1,2,3,4,5,0,1,2. tc=1 only while Q=5.
- Same configuration, mode 01 from reset -> Q = 5,4,3,2,1,0,5. tc=1 while Q=0.
- WIDTH=3, MAX_COUNT=7, mode 10 (macro defined) -> Q = 001,011,010,110,111,101,100,000. With the macro undefined -> Q = 1..7,0.
- WIDTH=3, mode 11, load_val=3'b010 (illegal) then en -> Q=000. Subsequent steps give Q = 001,011,111,110,100,000. tc=1 at 100.
- Mode 00 with load=1, en=1, load_val=7, MAX_COUNT=5 -> Q=5. With reset=1 on the same edge -> Q=0.
- Mode 00 running at Q=3, then en=0 for 4 cycles -> Q holds 3 and tc=0. Raising en resumes at Q=4.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the seq_gen sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_GRAY    = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_t;

  localparam int MAX_WIDTH = 16;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // A legal Johnson code has at most one transition between adjacent bits.
  function automatic logic johnson_legal(input logic [MAX_WIDTH-1:0] code, input int width);
    int transitions;
    transitions = 0;
    for (int i = 0; i < MAX_WIDTH-1; i++) begin
      if ((i < width-1) && (code[i] != code[i+1])) transitions++;
    end
    return (transitions <= 1);
  endfunction

endpackage

// File: rtl/seq_gen_tff.sv
// Single-bit T flip-flop with synchronous active-high reset.
module seq_tff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)  q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/seq_gen.sv
// Mode-selectable sequence generator built from T flip-flops.
// Define SEQ_GEN_GRAY_EN to build the Gray output encoder for mode 10.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] JOHN_TERM = {1'b1, {(WIDTH-1){1'b0}}};

  mode_t            modeSel;
  logic [WIDTH-1:0] st;
  logic [WIDTH-1:0] nextSt;
  logic [WIDTH-1:0] qNext;

  assign modeSel = mode_t'(mode);

  always_comb begin
    nextSt = st;
    tc     = 1'b0;
    if (load) begin
      if (modeSel == MODE_JOHNSON) nextSt = load_val;
      else                         nextSt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      case (modeSel)
        MODE_DOWN: begin
          if (st > MAX_VAL)     nextSt = '0;
          else if (st == '0)    nextSt = MAX_VAL;
          else                  nextSt = st - WIDTH'(1);
        end
        MODE_JOHNSON: begin
          if (johnson_legal(MAX_WIDTH'(st), WIDTH))
            nextSt = {st[WIDTH-2:0], ~st[WIDTH-1]};
          else
            nextSt = '0;
        end
        default: nextSt = (st >= MAX_VAL) ? '0 : st + WIDTH'(1);
      endcase
    end

    case (modeSel)
      MODE_DOWN:    tc = en && (st == '0);
      MODE_JOHNSON: tc = en && (st == JOHN_TERM);
      default:      tc = en && (st == MAX_VAL);
    endcase
  end

  // Output encoding is computed from the next state so Q never lags st.
  always_comb begin
    qNext = nextSt;
`ifdef SEQ_GEN_GRAY_EN
    if (modeSel == MODE_GRAY) qNext = WIDTH'(bin2gray(MAX_WIDTH'(nextSt)));
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    seq_tff u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (st[i] ^ nextSt[i]),
      .q     (st[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)          Q <= '0;
    else if (load || en) Q <= qNext;
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed scoreboard testbench for seq_gen (WIDTH=3, MAX_COUNT=5 and 7).
module tb_seq_gen;

  typedef struct {
    string      tag;
    logic [2:0] q;
    logic [2:0] q7;
    bit         chk7;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] q5, q7;
  logic       tc5, tc7;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  logic [2:0] upTbl   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
  logic [2:0] downTbl [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
  logic [2:0] binTbl  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
  logic [2:0] johnTbl [6] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
`ifdef SEQ_GEN_GRAY_EN
  logic [2:0] gray7Tbl [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] gray5Tbl [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b000, 3'b001, 3'b011};
`else
  logic [2:0] gray7Tbl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] gray5Tbl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
`endif

  seq_gen #(.WIDTH(3), .MAX_COUNT(5)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val), .Q(q5), .tc(tc5)
  );

  seq_gen #(.WIDTH(3), .MAX_COUNT(7)) dut7 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val), .Q(q7), .tc(tc7)
  );

  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard: empty queue");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (q5 === e.q) else begin
      errors++;
      $error("[TB] FAIL %s Q: got %b expected %b", e.tag, q5, e.q);
    end
    if (e.chk7) begin
      checks++;
      assert (q7 === e.q7) else begin
        errors++;
        $error("[TB] FAIL %s Q(max7): got %b expected %b", e.tag, q7, e.q7);
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit l, input bit e, input logic [1:0] m,
                               input logic [2:0] lv, input bit expTc, input string tag,
                               input logic [2:0] expQ, input bit chk7 = 1'b0,
                               input logic [2:0] expQ7 = 3'd0);
    exp_t item;
    reset    = r;
    load     = l;
    en       = e;
    mode     = m;
    load_val = lv;
    #1;
    checks++;
    assert (tc5 === expTc) else begin
      errors++;
      $error("[TB] FAIL %s tc: got %b expected %b", tag, tc5, expTc);
    end
    item.tag  = tag;
    item.q    = expQ;
    item.q7   = expQ7;
    item.chk7 = chk7;
    sb.push_back(item);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [2:0] prev;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 2'b00, 3'd0, 1'b0, "reset", 3'd0, 1'b1, 3'd0);

    prev = 3'd0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 2'b00, 3'd0, prev == 3'd5, "up", upTbl[i]);
      prev = upTbl[i];
    end

    applyStimulus(1, 0, 0, 2'b01, 3'd0, 1'b0, "reset2", 3'd0);
    prev = 3'd0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 1, 2'b01, 3'd0, prev == 3'd0, "down", downTbl[i]);
      prev = downTbl[i];
    end

    applyStimulus(1, 0, 0, 2'b10, 3'd0, 1'b0, "reset3", 3'd0, 1'b1, 3'd0);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 1, 2'b10, 3'd0, binTbl[i] == 3'd5, "gray", gray5Tbl[i], 1'b1, gray7Tbl[i]);

    applyStimulus(0, 1, 0, 2'b11, 3'b010, 1'b0, "john_load", 3'b010);
    applyStimulus(0, 0, 1, 2'b11, 3'd0, 1'b0, "john_fix", 3'b000);
    prev = 3'b000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 2'b11, 3'd0, prev == 3'b100, "john", johnTbl[i]);
      prev = johnTbl[i];
    end

    applyStimulus(0, 1, 0, 2'b11, 3'b111, 1'b0, "john_load7", 3'b111);
    applyStimulus(0, 0, 1, 2'b01, 3'd0, 1'b0, "down_over", 3'd0);

    applyStimulus(0, 1, 1, 2'b00, 3'd7, 1'b0, "load_clamp", 3'd5);
    applyStimulus(1, 1, 1, 2'b00, 3'd7, 1'b1, "reset_wins", 3'd0);

    for (int i = 1; i <= 3; i++)
      applyStimulus(0, 0, 1, 2'b00, 3'd0, 1'b0, "run", 3'(i));
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 2'b00, 3'd0, 1'b0, "hold", 3'd3);
    applyStimulus(0, 0, 1, 2'b00, 3'd0, 1'b0, "resume", 3'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
